// File: rtl/vga_pkg.sv
// Shared VGA types: RGB565 pixel and the pixel FIFO storage entry.
package vga_pkg;

  localparam int unsigned PixelFifoDepthDefault = 16;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic    sof;
    rgb565_t pix;
  } pixel_fifo_entry_t;

endpackage

// File: rtl/vga_pixel_fifo_if.sv
// Producer/consumer bundle of the pixel FIFO; signal directions are named
// from the FIFO's point of view. Stats outputs exist only with
// VGA_PIXEL_FIFO_STATS_EN.
interface vga_pixel_fifo_if #(
  parameter int unsigned DEPTH = vga_pkg::PixelFifoDepthDefault
);
  import vga_pkg::*;

  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic            flush_i;
  logic            wr_valid_i;
  logic            wr_ready_o;
  rgb565_t         wr_data_i;
  logic            wr_sof_i;
  logic            rd_i;
  rgb565_t         data_o;
  logic            sof_o;
  logic            empty_o;
  logic [LvlW-1:0] level_o;
  logic            almost_full_o;
  logic            underflow_o;
`ifdef VGA_PIXEL_FIFO_STATS_EN
  logic [15:0]     underflow_cnt_o;
  logic [LvlW-1:0] max_level_o;
`endif

  modport slave (
    input  flush_i, wr_valid_i, wr_data_i, wr_sof_i, rd_i,
    output wr_ready_o, data_o, sof_o, empty_o, level_o, almost_full_o,
`ifdef VGA_PIXEL_FIFO_STATS_EN
    output underflow_cnt_o, max_level_o,
`endif
    output underflow_o
  );

  modport master (
    output flush_i, wr_valid_i, wr_data_i, wr_sof_i, rd_i,
    input  wr_ready_o, data_o, sof_o, empty_o, level_o, almost_full_o,
`ifdef VGA_PIXEL_FIFO_STATS_EN
    input  underflow_cnt_o, max_level_o,
`endif
    input  underflow_o
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear wins, increment stops at the maximum value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_pixel_fifo.sv
// First-word-fall-through pixel FIFO feeding vga_ctrl (pixel_clk domain).
// Optional statistics (underflow count, high-water mark) under the
// VGA_PIXEL_FIFO_STATS_EN macro.
module vga_pixel_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH          = PixelFifoDepthDefault,
  parameter int unsigned ALMOST_FULL_TH = 12
) (
  input  logic            clk_i,
  input  logic            rst_i,
  vga_pixel_fifo_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  pixel_fifo_entry_t mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              almost_full_q, almost_full_d;
  logic              underflow_q, underflow_d;
  logic              wr_ready, wr_en, rd_en;

  // Handshake qualifiers; ready depends only on the stored count.
  assign wr_ready = (count_q != CntW'(DEPTH));
  assign wr_en    = bus.wr_valid_i && wr_ready && !bus.flush_i;
  assign rd_en    = bus.rd_i && !empty_q && !bus.flush_i;

  // Pointer/count next state; flush overrides any write or read.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = 1'b0;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      underflow_d = bus.rd_i && empty_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
    empty_d       = (count_d == '0);
    almost_full_d = (count_d >= CntW'(ALMOST_FULL_TH));
  end

  // Control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      almost_full_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      almost_full_q <= almost_full_d;
      underflow_q   <= underflow_d;
    end
  end

  // Storage array; cleared by reset only, never by flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= '{sof: bus.wr_sof_i, pix: bus.wr_data_i};
    end
  end

  assign bus.wr_ready_o    = wr_ready;
  assign bus.data_o        = mem_q[rd_ptr_q].pix;
  assign bus.sof_o         = mem_q[rd_ptr_q].sof;
  assign bus.empty_o       = empty_q;
  assign bus.level_o       = count_q;
  assign bus.almost_full_o = almost_full_q;
  assign bus.underflow_o   = underflow_q;

`ifdef VGA_PIXEL_FIFO_STATS_EN
  logic [CntW-1:0] max_level_q, max_level_d;

  // High-water mark of the stored count, cleared by flush.
  always_comb begin
    max_level_d = max_level_q;
    if (bus.flush_i)                max_level_d = '0;
    else if (count_q > max_level_q) max_level_d = count_q;
  end

  // High-water mark register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) max_level_q <= '0;
    else       max_level_q <= max_level_d;
  end

  sat_counter #(
    .WIDTH (16)
  ) u_underflow_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (underflow_d),
    .clr_i (bus.flush_i),
    .cnt_o (bus.underflow_cnt_o)
  );

  assign bus.max_level_o = max_level_q;
`endif

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Directed self-checking bench for vga_pixel_fifo (DEPTH 16, threshold 12).
module tb_vga_pixel_fifo;
  import vga_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  vga_pixel_fifo_if #(.DEPTH(16)) bus ();

  vga_pixel_fifo #(
    .DEPTH          (16),
    .ALMOST_FULL_TH (12)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic s, input logic r, input logic f);
    bus.wr_valid_i = v;
    bus.wr_data_i  = rgb565_t'(d);
    bus.wr_sof_i   = s;
    bus.rd_i       = r;
    bus.flush_i    = f;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_empty"}, 32'(bus.empty_o), 32'd1);
    check_eq({tag, "_ready"}, 32'(bus.wr_ready_o), 32'd1);
    check_eq({tag, "_data"}, 32'(bus.data_o), 32'h0);
    check_eq({tag, "_sof"}, 32'(bus.sof_o), 32'd0);
    check_eq({tag, "_level"}, 32'(bus.level_o), 32'd0);
    check_eq({tag, "_af"}, 32'(bus.almost_full_o), 32'd0);
    check_eq({tag, "_unf"}, 32'(bus.underflow_o), 32'd0);
`ifdef VGA_PIXEL_FIFO_STATS_EN
    check_eq({tag, "_ucnt"}, 32'(bus.underflow_cnt_o), 32'd0);
    check_eq({tag, "_maxlvl"}, 32'(bus.max_level_o), 32'd0);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    check_reset_vals("reset");

    // 1: single write is visible the next cycle
    drive(1'b1, 16'hF800, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check_eq("t1_empty", 32'(bus.empty_o), 32'd0);
    check_eq("t1_data", 32'(bus.data_o), 32'hF800);
    check_eq("t1_sof", 32'(bus.sof_o), 32'd1);
    check_eq("t1_level", 32'(bus.level_o), 32'd1);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check_eq("t1_flush_level", 32'(bus.level_o), 32'd0);
    check_eq("t1_flush_empty", 32'(bus.empty_o), 32'd1);
    check_eq("t1_flush_stale", 32'(bus.data_o), 32'hF800);

    // 2: fill to full, refused write while popping
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      step();
      if (i == 10) check_eq("t2_af_at11", 32'(bus.almost_full_o), 32'd0);
      if (i == 11) check_eq("t2_af_at12", 32'(bus.almost_full_o), 32'd1);
      if (i == 14) check_eq("t2_ready_at15", 32'(bus.wr_ready_o), 32'd1);
    end
    check_eq("t2_ready_full", 32'(bus.wr_ready_o), 32'd0);
    check_eq("t2_level_full", 32'(bus.level_o), 32'd16);
    check_eq("t2_af_full", 32'(bus.almost_full_o), 32'd1);
    drive(1'b1, 16'h00AA, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check_eq("t2_level_refused", 32'(bus.level_o), 32'd15);
    check_eq("t2_head", 32'(bus.data_o), 32'h0001);
    check_eq("t2_ready_again", 32'(bus.wr_ready_o), 32'd1);
    for (int i = 1; i < 16; i++) begin
      check_eq("t2_drain", 32'(bus.data_o), 32'(i));
      bus.rd_i = 1'b1;
      step();
    end
    bus.rd_i = 1'b0;
    check_eq("t2_drained_empty", 32'(bus.empty_o), 32'd1);
    check_eq("t2_drained_level", 32'(bus.level_o), 32'd0);
`ifdef VGA_PIXEL_FIFO_STATS_EN
    check_eq("t2_maxlvl", 32'(bus.max_level_o), 32'd16);
`endif

    // 3: steady state at level 8 across pointer wrap
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 16'h0100 + 16'(k), 1'b0, 1'b0, 1'b0);
      step();
    end
    check_eq("t3_level_fill", 32'(bus.level_o), 32'd8);
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 16'h0108 + 16'(c), 1'b0, 1'b1, 1'b0);
      check_eq("t3_order", 32'(bus.data_o), 32'h0100 + 32'(c));
      step();
      check_eq("t3_level", 32'(bus.level_o), 32'd8);
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step();
    bus.flush_i = 1'b0;
    check_eq("t3_flush_empty", 32'(bus.empty_o), 32'd1);

    // 4: three underflows, then write plus underflow together
    bus.rd_i = 1'b1;
    for (int u = 0; u < 3; u++) begin
      step();
      check_eq("t4_unf", 32'(bus.underflow_o), 32'd1);
      check_eq("t4_level", 32'(bus.level_o), 32'd0);
    end
`ifdef VGA_PIXEL_FIFO_STATS_EN
    check_eq("t4_ucnt3", 32'(bus.underflow_cnt_o), 32'd3);
`endif
    drive(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check_eq("t4_wr_unf", 32'(bus.underflow_o), 32'd1);
    check_eq("t4_wr_level", 32'(bus.level_o), 32'd1);
    check_eq("t4_wr_data", 32'(bus.data_o), 32'h1234);
    step();
    check_eq("t4_unf_end", 32'(bus.underflow_o), 32'd0);
`ifdef VGA_PIXEL_FIFO_STATS_EN
    check_eq("t4_ucnt4", 32'(bus.underflow_cnt_o), 32'd4);
`endif

    // 5: flush beats simultaneous write and read at level 5
    bus.flush_i = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'h0500 + 16'(k), 1'b0, 1'b0, 1'b0);
      step();
    end
    check_eq("t5_level5", 32'(bus.level_o), 32'd5);
    drive(1'b1, 16'h0BAD, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check_eq("t5_level", 32'(bus.level_o), 32'd0);
    check_eq("t5_empty", 32'(bus.empty_o), 32'd1);
    check_eq("t5_unf", 32'(bus.underflow_o), 32'd0);
    check_eq("t5_stale", 32'(bus.data_o), 32'h0500);
`ifdef VGA_PIXEL_FIFO_STATS_EN
    check_eq("t5_ucnt", 32'(bus.underflow_cnt_o), 32'd0);
`endif
    drive(1'b1, 16'h0777, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check_eq("t5_after_level", 32'(bus.level_o), 32'd1);
    check_eq("t5_after_data", 32'(bus.data_o), 32'h0777);

    // 6: asynchronous reset between edges at level 9
    bus.flush_i = 1'b1;
    step();
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 16'h0900 + 16'(k), (k == 0), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check_eq("t6_level9", 32'(bus.level_o), 32'd9);
    check_eq("t6_head", 32'(bus.data_o), 32'h0900);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("t6_async");
    step();
    rst = 1'b0;
    step();
    check_eq("t6_post_level", 32'(bus.level_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
